// File: rtl/puf_pkg.sv
// Purpose: shared types and constants for the arbiter-PUF evaluation block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

    // Evaluation sequencer states.
    typedef enum logic [2:0] {
        PUF_IDLE   = 3'd0,
        PUF_LAUNCH = 3'd1,
        PUF_SETTLE = 3'd2,
        PUF_SAMPLE = 3'd3,
        PUF_DONE   = 3'd4
    } puf_eval_state_t;

    // Default feedback mask for the challenge LFSR (only the low N_STAGES bits are used).
    localparam logic [63:0] PUF_DEFAULT_TAPS = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/puf_chain_eval_if.sv
// Purpose: request/response bundle between a requester and puf_chain_eval.
// Latency: n/a (wires only).
// Backpressure: none; the requester watches busy and its start is dropped while busy.
// Ports: start/challenge from requester; busy/done/response/stable back to requester.
interface puf_chain_eval_if #(
    parameter int N_STAGES = 64,
    parameter int RESP_W   = 8
) ();
    logic                start;
    logic [N_STAGES-1:0] challenge;
    logic                busy;
    logic                done;
    logic [RESP_W-1:0]   response;
    logic [RESP_W-1:0]   stable;

    modport master (
        output start, challenge,
        input  busy, done, response, stable
    );

    modport slave (
        input  start, challenge,
        output busy, done, response, stable
    );
endinterface

// File: rtl/puf_lfsr.sv
// Purpose: challenge register that loads a seed and steps as a Fibonacci LFSR.
// Latency: q updates on the clock edge after load/step.
// Backpressure: none; load has priority over step.
// Ports: clk, rst_n, load, step, seed[N_STAGES], q[N_STAGES].
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int          N_STAGES = 64,
    parameter logic [63:0] TAPS     = PUF_DEFAULT_TAPS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [N_STAGES-1:0] seed,
    output logic [N_STAGES-1:0] q
);
    localparam logic [N_STAGES-1:0] MASK = TAPS[N_STAGES-1:0];

    logic [N_STAGES-1:0] q_q;
    logic [N_STAGES-1:0] q_d;

    // An all-zero state is a fixed point and is deliberately left alone.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (step) begin
            q_d = {q_q[N_STAGES-2:0], ^(q_q & MASK)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/puf_chain_eval.sv
// Purpose: drives an external arbiter chain, majority-votes NUM_EVALS races per response bit.
// Latency: done in cycle 1+RESP_W*NUM_EVALS*(SETTLE_CYC+2) after the start cycle.
// Backpressure: start is only taken in IDLE; starts while busy (or in DONE) are dropped.
// Ports: clk, rst_n, req (slave: start/challenge in, busy/done/response/stable out),
//        chain_chal/chain_launch/chain_en to the chain, chain_resp (async) from the arbiter.
module puf_chain_eval
    import puf_pkg::*;
#(
    parameter int          N_STAGES   = 64,
    parameter int          RESP_W     = 8,
    parameter int          NUM_EVALS  = 5,
    parameter int          SETTLE_CYC = 4,
    parameter logic [63:0] TAPS       = PUF_DEFAULT_TAPS
) (
    input  logic                clk,
    input  logic                rst_n,
    puf_chain_eval_if.slave     req,
    output logic [N_STAGES-1:0] chain_chal,
    output logic                chain_launch,
    output logic                chain_en,
    input  logic                chain_resp
);
    localparam int ONES_W = $clog2(NUM_EVALS + 1);
    localparam int EVAL_W = (NUM_EVALS > 1)  ? $clog2(NUM_EVALS)  : 1;
    localparam int BIT_W  = (RESP_W > 1)     ? $clog2(RESP_W)     : 1;
    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [EVAL_W-1:0] EVAL_LAST = EVAL_W'(NUM_EVALS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_W - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [ONES_W-1:0] ONES_HALF = ONES_W'(NUM_EVALS / 2);
    localparam logic [ONES_W-1:0] ONES_ALL  = ONES_W'(NUM_EVALS);

    // An even vote count could tie, so refuse to build.
    if ((NUM_EVALS % 2) == 0 || NUM_EVALS < 1) begin : g_bad_num_evals
        $error("puf_chain_eval: NUM_EVALS must be odd and >= 1");
    end
    if (N_STAGES < 2) begin : g_bad_n_stages
        $error("puf_chain_eval: N_STAGES must be >= 2");
    end

    puf_eval_state_t     state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [EVAL_W-1:0]   eval_q, eval_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [ONES_W-1:0]   ones_sum;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [RESP_W-1:0]   stab_q, stab_d;
    logic                sync1_d, sync2_d;
    logic                lfsr_load, lfsr_step;
    logic [N_STAGES-1:0] chal_q;

    // chain_resp is asynchronous to clk; keep both stages intact through optimisation.
    (* keep = "true", dont_touch = "true" *) logic sync1_q;
    (* keep = "true", dont_touch = "true" *) logic sync2_q;

    puf_lfsr #(
        .N_STAGES (N_STAGES),
        .TAPS     (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (req.challenge),
        .q     (chal_q)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        eval_d    = eval_q;
        bit_d     = bit_q;
        ones_d    = ones_q;
        resp_d    = resp_q;
        stab_d    = stab_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        sync1_d   = chain_resp;
        sync2_d   = sync1_q;
        // Vote tally including the sample taken this cycle.
        ones_sum  = ones_q + ONES_W'(sync2_q);

        case (state_q)
            PUF_IDLE: begin
                if (req.start) begin
                    state_d   = PUF_LAUNCH;
                    lfsr_load = 1'b1;
                    ones_d    = '0;
                    eval_d    = '0;
                    bit_d     = '0;
                    settle_d  = '0;
                end
            end
            PUF_LAUNCH: begin
                state_d  = PUF_SETTLE;
                settle_d = '0;
            end
            PUF_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d  = PUF_SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            PUF_SAMPLE: begin
                ones_d = ones_sum;
                if (eval_q == EVAL_LAST) begin
                    // Commit bit: majority value, and whether every race agreed.
                    resp_d[bit_q] = (ones_sum > ONES_HALF);
                    stab_d[bit_q] = (ones_sum == '0) || (ones_sum == ONES_ALL);
                    ones_d    = '0;
                    eval_d    = '0;
                    bit_d     = bit_q + BIT_W'(1);
                    lfsr_step = 1'b1;
                    state_d   = (bit_q == BIT_LAST) ? PUF_DONE : PUF_LAUNCH;
                end else begin
                    eval_d  = eval_q + EVAL_W'(1);
                    state_d = PUF_LAUNCH;
                end
            end
            PUF_DONE: begin
                state_d = PUF_IDLE;
            end
            default: begin
                state_d = PUF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PUF_IDLE;
            settle_q <= '0;
            eval_q   <= '0;
            bit_q    <= '0;
            ones_q   <= '0;
            resp_q   <= '0;
            stab_q   <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            eval_q   <= eval_d;
            bit_q    <= bit_d;
            ones_q   <= ones_d;
            resp_q   <= resp_d;
            stab_q   <= stab_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    // Outputs decode straight from flops so reset drops them immediately.
    assign req.busy     = (state_q != PUF_IDLE);
    assign req.done     = (state_q == PUF_DONE);
    assign req.response = resp_q;
    assign req.stable   = stab_q;
    assign chain_chal   = chal_q;
    assign chain_launch = (state_q == PUF_LAUNCH);
    assign chain_en     = (state_q == PUF_LAUNCH) || (state_q == PUF_SETTLE);
endmodule

// File: tb/tb_puf_chain_eval.sv
// Purpose: scoreboard bench for puf_chain_eval (8 stages, 4 bits, 3 evals, 2 settle cycles).
// Latency: expects done 49 cycles after the start cycle.
// Backpressure: exercises dropped starts while busy and in DONE.
module tb_puf_chain_eval;
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       chain_resp = 1'b0;
    logic [7:0] chain_chal;
    logic       chain_launch;
    logic       chain_en;

    puf_chain_eval_if #(.N_STAGES(8), .RESP_W(4)) req_if ();

    puf_chain_eval #(
        .N_STAGES   (8),
        .RESP_W     (4),
        .NUM_EVALS  (3),
        .SETTLE_CYC (2),
        .TAPS       (64'hB8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_if),
        .chain_chal   (chain_chal),
        .chain_launch (chain_launch),
        .chain_en     (chain_en),
        .chain_resp   (chain_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] resp;
        logic [3:0] stab;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] chal_sb[$];

    int         total     = 0;
    int         bad       = 0;
    int         launches  = 0;
    int         mode      = 0;   // 0: tied 1, 1: per-launch pattern, 2: toggle each cycle
    int         pidx      = 0;
    int         start_cyc = 0;
    logic [2:0] pat       = 3'b101;
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic fail(input string name, input string got, input string req);
        total++;
        bad++;
        $display("FAIL %s got=%s required=%s (t=%0t)", name, got, req, $time);
    endtask

    // Expected result plus the challenge seen at each of the 12 launches ({c3,c2,c1,c0}).
    task automatic push_exp(input logic [3:0] resp, input logic [3:0] stab,
                            input int dcyc, input logic [31:0] chals);
        exp_t e;
        e.resp = resp;
        e.stab = stab;
        e.cyc  = dcyc;
        sb.push_back(e);
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 3; k++)
                chal_sb.push_back(chals[8*b +: 8]);
    endtask

    // Start in the current cycle (cycle 0); done is due in cycle 49.
    // Toggle mode: SAMPLE at cycle 4(j+1) sees chain_resp from cycle 4j+2, whose
    // driven value is ~cyc[0] = ~start_cyc[0] for every sample.
    task automatic issue(input logic [7:0] chal, input logic [3:0] resp, input logic [3:0] stab,
                         input logic [31:0] chals, input bit tog);
        @(posedge clk); #1;
        req_if.start     = 1'b1;
        req_if.challenge = chal;
        start_cyc        = cyc;
        if (tog) push_exp(start_cyc[0] ? 4'h0 : 4'hF, stab, cyc + 49, chals);
        else     push_exp(resp, stab, cyc + 49, chals);
        @(posedge clk); #1;
        req_if.start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || req_if.busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) fail("idle_timeout", "busy", "idle");
        chk("chal_drained", 32'(chal_sb.size()), 0);
    endtask

    // Chain model.
    initial forever begin
        @(posedge clk); #1;
        case (mode)
            0: chain_resp = 1'b1;
            1: if (chain_launch) begin
                   chain_resp = pat[pidx];
                   pidx = (pidx == 2) ? 0 : pidx + 1;
               end
            default: chain_resp = ~cyc[0];
        endcase
    end

    // Monitor: checks chain_chal per launch, and pops the scoreboard on each done.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (chain_launch) begin
                launches++;
                chk("chain_en_at_launch", 32'(chain_en), 1);
                if (chal_sb.size() == 0) fail("unexpected_launch", "launch", "none");
                else chk("chain_chal", 32'(chain_chal), 32'(chal_sb.pop_front()));
            end
            if (req_if.done) begin
                if (prev_done) fail("done_pulse_width", "2+cycles", "1cycle");
                if (sb.size() == 0) begin
                    fail("unexpected_done", "done", "none");
                end else begin
                    e = sb.pop_front();
                    chk("response", 32'(req_if.response), 32'(e.resp));
                    chk("stable", 32'(req_if.stable), 32'(e.stab));
                    chk("done_cycle", cyc, e.cyc);
                    chk("launch_count", launches, 12);
                end
                launches = 0;
            end
            prev_done = req_if.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running required=finished total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        req_if.start     = 1'b0;
        req_if.challenge = 8'h00;
        #1 rst_n = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(req_if.busy), 0);
        chk("rst_done", 32'(req_if.done), 0);
        chk("rst_launch", 32'(chain_launch), 0);
        chk("rst_chain_en", 32'(chain_en), 0);
        chk("rst_response", 32'(req_if.response), 0);
        chk("rst_stable", 32'(req_if.stable), 0);
        chk("rst_chain_chal", 32'(chain_chal), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // All races agree on 1; challenge 01 shifts 01,02,04,08.
        mode = 0;
        issue(8'h01, 4'hF, 4'hF, 32'h08040201, 1'b0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("resp_hold", 32'(req_if.response), 32'hF);
        chk("stab_hold", 32'(req_if.stable), 32'hF);

        // 1,0,1 per bit: majority 1, never unanimous. C3 -> 87 -> 0F -> 1F.
        mode = 1; pat = 3'b101; pidx = 0;
        issue(8'hC3, 4'hF, 4'h0, 32'h1F0F87C3, 1'b0);
        wait_idle();

        // 0,1,0 per bit with a zero challenge that must stay zero.
        pat = 3'b010; pidx = 0;
        issue(8'h00, 4'h0, 4'h0, 32'h00000000, 1'b0);
        wait_cyc(start_cyc + 10);
        chk("resp_before_commit", 32'(req_if.response), 32'hF);
        wait_idle();

        // chain_resp toggling every cycle; samples lag by two flops.
        mode = 2;
        issue(8'h01, 4'h0, 4'hF, 32'h08040201, 1'b1);
        wait_idle();

        // Starts at cycle 5 (busy) and 49 (DONE) are dropped; held into cycle 50 it is taken.
        mode = 0;
        issue(8'h01, 4'hF, 4'hF, 32'h08040201, 1'b0);
        k = start_cyc;
        wait_cyc(k + 5);
        req_if.start     = 1'b1;
        req_if.challenge = 8'hFF;
        chk("busy_mid_run", 32'(req_if.busy), 1);
        @(posedge clk); #1;
        req_if.start     = 1'b0;
        req_if.challenge = 8'h01;
        wait_cyc(k + 49);
        req_if.start     = 1'b1;
        req_if.challenge = 8'h80;
        // Second run seeded at cycle 50: 80 -> 01 -> 02 -> 04.
        push_exp(4'hF, 4'hF, k + 50 + 49, 32'h04020180);
        wait_cyc(k + 51);
        req_if.start = 1'b0;
        wait_idle();

        // Reset in cycle 20 aborts the run without a done pulse.
        issue(8'h5A, 4'hF, 4'hF, 32'hD269B45A, 1'b0);
        wait_cyc(start_cyc + 20);
        chk("busy_before_reset", 32'(req_if.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(req_if.busy), 0);
        chk("abort_chain_en", 32'(chain_en), 0);
        chk("abort_done", 32'(req_if.done), 0);
        chk("abort_response", 32'(req_if.response), 0);
        chk("abort_stable", 32'(req_if.stable), 0);
        chk("abort_chain_chal", 32'(chain_chal), 0);
        sb.delete();
        chal_sb.delete();
        launches = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        issue(8'h01, 4'hF, 4'hF, 32'h08040201, 1'b0);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
